// File: rtl/mem_req_scheduler_if.sv
// Block-transfer bundle between the two caches, the scheduler and memory_controller.
// The master modport is the scheduler's view; slave is the caches/memory side.
interface mem_req_scheduler_if #(
  parameter int ADDR_W  = 64,
  parameter int BLOCKSZ = 512
);
  logic               icache_req;
  logic [ADDR_W-1:0]  icache_address;
  logic [BLOCKSZ-1:0] icache_data_out;
  logic               icache_operation_complete;

  logic               dcache_req;
  logic [ADDR_W-1:0]  dcache_address;
  logic               dcache_wr_en;
  logic [BLOCKSZ-1:0] dcache_data_in;
  logic [BLOCKSZ-1:0] dcache_data_out;
  logic               dcache_operation_complete;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_address;
  logic               mem_wr_en;
  logic [BLOCKSZ-1:0] mem_data_out;
  logic [BLOCKSZ-1:0] data_from_mem;
  logic               mem_data_valid;

  logic               flush;
  logic               busy;

  modport master (
    input  icache_req, icache_address,
    output icache_data_out, icache_operation_complete,
    input  dcache_req, dcache_address, dcache_wr_en, dcache_data_in,
    output dcache_data_out, dcache_operation_complete,
    output mem_req, mem_address, mem_wr_en, mem_data_out,
    input  data_from_mem, mem_data_valid,
    input  flush,
    output busy
  );

  modport slave (
    output icache_req, icache_address,
    input  icache_data_out, icache_operation_complete,
    output dcache_req, dcache_address, dcache_wr_en, dcache_data_in,
    input  dcache_data_out, dcache_operation_complete,
    input  mem_req, mem_address, mem_wr_en, mem_data_out,
    output data_from_mem, mem_data_valid,
    output flush,
    input  busy
  );
endinterface

// File: rtl/mem_req_scheduler.sv
// Single-outstanding block request scheduler between icache/dcache and memory_controller.
// Optional macro STARVE_GUARD_EN: bounds consecutive dcache grants while icache waits.
module mem_req_scheduler #(
  parameter int ADDR_W       = 64,
  parameter int BLOCKSZ      = 512,
  parameter int BLK_OFF      = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_req_scheduler_if.master  bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << BLK_OFF) - ADDR_W'(1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic               grant_icache_reg;
  logic               drop_reg;
  logic [ADDR_W-1:0]  mem_address_reg;
  logic               mem_wr_en_reg;
  logic [BLOCKSZ-1:0] mem_data_out_reg;
  logic [BLOCKSZ-1:0] icache_data_reg;
  logic [BLOCKSZ-1:0] dcache_data_reg;

  logic grant_en;
  logic grant_icache;
  logic capture_en;
  logic drop_set;
  logic icache_ok;
  logic starve_hit;

  // A flushed fetch must not even start.
  assign icache_ok = bus.icache_req && !bus.flush;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] starve_cnt_reg;

  assign starve_hit = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else if (grant_en) begin
      if (grant_icache) begin
        starve_cnt_reg <= '0;
      end else if (bus.icache_req && !bus.flush && !starve_hit) begin
        starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
      end
    end
  end
`else
  // Strict dcache priority: the guard can never fire.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_en     = 1'b0;
    grant_icache = 1'b0;
    capture_en   = 1'b0;
    drop_set     = 1'b0;

    bus.mem_req                   = 1'b0;
    bus.busy                      = 1'b1;
    bus.icache_operation_complete = 1'b0;
    bus.dcache_operation_complete = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.dcache_req || icache_ok) begin
          grant_en     = 1'b1;
          grant_icache = icache_ok && (!bus.dcache_req || starve_hit);
          state_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.mem_req = 1'b1;
        drop_set    = grant_icache_reg && bus.flush;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        drop_set = grant_icache_reg && bus.flush;
        if (bus.mem_data_valid) begin
          capture_en = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.icache_operation_complete = grant_icache_reg && !drop_reg;
        bus.dcache_operation_complete = !grant_icache_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_icache_reg <= 1'b0;
      drop_reg         <= 1'b0;
      mem_address_reg  <= '0;
      mem_wr_en_reg    <= 1'b0;
      mem_data_out_reg <= '0;
      icache_data_reg  <= '0;
      dcache_data_reg  <= '0;
    end else begin
      if (grant_en) begin
        grant_icache_reg <= grant_icache;
        drop_reg         <= 1'b0;
        if (grant_icache) begin
          mem_address_reg  <= bus.icache_address & ALIGN_MASK;
          mem_wr_en_reg    <= 1'b0;
          mem_data_out_reg <= '0;
        end else begin
          mem_address_reg  <= bus.dcache_address & ALIGN_MASK;
          mem_wr_en_reg    <= bus.dcache_wr_en;
          mem_data_out_reg <= bus.dcache_data_in;
        end
      end

      if (drop_set) begin
        drop_reg <= 1'b1;
      end

      // A flush arriving with the data squashes it just like an earlier one.
      if (capture_en) begin
        if (grant_icache_reg) begin
          if (!drop_reg && !bus.flush) begin
            icache_data_reg <= bus.data_from_mem;
          end
        end else if (!mem_wr_en_reg) begin
          dcache_data_reg <= bus.data_from_mem;
        end
      end
    end
  end

  assign bus.mem_address     = mem_address_reg;
  assign bus.mem_wr_en       = mem_wr_en_reg;
  assign bus.mem_data_out    = mem_data_out_reg;
  assign bus.icache_data_out = icache_data_reg;
  assign bus.dcache_data_out = dcache_data_reg;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration, flush and data return.
`timescale 1ns/1ps
module tb_mem_req_scheduler;
  localparam int ADDR_W  = 64;
  localparam int BLOCKSZ = 512;
  localparam int LIMIT   = 4;

  typedef logic [BLOCKSZ-1:0] blk_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_req_scheduler_if #(.ADDR_W(ADDR_W), .BLOCKSZ(BLOCKSZ)) bus ();

  mem_req_scheduler #(
    .ADDR_W(ADDR_W), .BLOCKSZ(BLOCKSZ), .BLK_OFF(6), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  blk_t  ref_ic_data;
  blk_t  ref_dc_data;
  int    ref_starve;
  string grant_log;

  task automatic check(input string tag, input blk_t obs, input blk_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < BLOCKSZ / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic blk_t fill8(input logic [7:0] v);
    return {(BLOCKSZ / 8){v}};
  endfunction

  // Arbitration rule: dcache first, icache ignored under flush, guard overrides.
  function automatic bit model_pick_icache(input bit ireq, input bit dreq, input bit fl);
    if (!ireq || fl) return 1'b0;
    if (!dreq) return 1'b1;
`ifdef STARVE_GUARD_EN
    return ref_starve == LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   bus.busy, '0);
    check({tag, "_mreq"},   bus.mem_req, '0);
    check({tag, "_maddr"},  bus.mem_address, '0);
    check({tag, "_mwr"},    bus.mem_wr_en, '0);
    check({tag, "_mdata"},  bus.mem_data_out, '0);
    check({tag, "_icdone"}, bus.icache_operation_complete, '0);
    check({tag, "_dcdone"}, bus.dcache_operation_complete, '0);
    check({tag, "_icdata"}, bus.icache_data_out, '0);
    check({tag, "_dcdata"}, bus.dcache_data_out, '0);
  endtask

  // Entered in an IDLE cycle with requests already driven; leaves in the next IDLE cycle.
  task automatic do_txn(input int lat, input int flush_at, input blk_t rdata);
    bit    exp_i, exp_wr, dropped;
    addr_t exp_addr;
    blk_t  exp_wd;

    exp_i = model_pick_icache(bus.icache_req, bus.dcache_req, bus.flush);
`ifdef STARVE_GUARD_EN
    if (exp_i) ref_starve = 0;
    else if (bus.icache_req && !bus.flush && ref_starve < LIMIT) ref_starve++;
`endif
    exp_addr      = exp_i ? bus.icache_address : bus.dcache_address;
    exp_addr[5:0] = 6'd0;
    exp_wr        = !exp_i && bus.dcache_wr_en;
    exp_wd        = exp_i ? '0 : bus.dcache_data_in;
    dropped       = 1'b0;
    check("idle_busy", bus.busy, '0);

    tick();
    check("req_pulse", bus.mem_req, 1'b1);
    check("req_busy",  bus.busy, 1'b1);
    check("req_addr",  bus.mem_address, exp_addr);
    check("req_wr",    bus.mem_wr_en, exp_wr);
    check("req_wdata", bus.mem_data_out, exp_wd);

    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) begin
        check("wait_noreq", bus.mem_req, '0);
        check("wait_addr",  bus.mem_address, exp_addr);
        check("wait_done",  {bus.icache_operation_complete, bus.dcache_operation_complete}, '0);
      end
      bus.flush          = (flush_at == k - 1);
      bus.mem_data_valid = (k == lat + 1);
      bus.data_from_mem  = (k == lat + 1) ? rdata : rand_blk();
      if (exp_i && bus.flush) dropped = 1'b1;
      tick();
    end
    bus.flush          = 1'b0;
    bus.mem_data_valid = 1'b0;

    if (!exp_i && !exp_wr) ref_dc_data = rdata;
    if (exp_i && !dropped) ref_ic_data = rdata;

    check("resp_icdone", bus.icache_operation_complete, exp_i && !dropped);
    check("resp_dcdone", bus.dcache_operation_complete, !exp_i);
    check("resp_icdata", bus.icache_data_out, ref_ic_data);
    check("resp_dcdata", bus.dcache_data_out, ref_dc_data);
    check("resp_busy",   bus.busy, 1'b1);
    grant_log = {grant_log, bus.dcache_operation_complete ? "D" :
                            bus.icache_operation_complete ? "I" : "-"};
    if (exp_i) bus.icache_req = 1'b0;
    else       bus.dcache_req = 1'b0;

    tick();
    check("after_busy", bus.busy, '0);
    check("after_done", {bus.icache_operation_complete, bus.dcache_operation_complete}, '0);
    check("after_addr", bus.mem_address, exp_addr);
    check("after_ic",   bus.icache_data_out, ref_ic_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    int    lat;
    int    fat;

    bus.icache_req     = 1'b0;
    bus.icache_address = '0;
    bus.dcache_req     = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wr_en   = 1'b0;
    bus.dcache_data_in = '0;
    bus.data_from_mem  = '0;
    bus.mem_data_valid = 1'b0;
    bus.flush          = 1'b0;
    ref_ic_data = '0;
    ref_dc_data = '0;
    ref_starve  = 0;
    grant_log   = "";

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Stray valid while idle is ignored
    bus.mem_data_valid = 1'b1;
    bus.data_from_mem  = rand_blk();
    tick();
    bus.mem_data_valid = 1'b0;
    check_all_zero("idle_valid");

    // Basic icache fetch, L=3
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h1043;
    do_txn(3, -1, fill8(8'hA5));
    check("t1_icdata", bus.icache_data_out, fill8(8'hA5));

    // Simultaneous: dcache write wins, then icache
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h3008;
    bus.dcache_req     = 1'b1;
    bus.dcache_address = 64'h2000;
    bus.dcache_wr_en   = 1'b1;
    bus.dcache_data_in = fill8(8'h11);
    do_txn(2, -1, rand_blk());
    check("t2_ic_kept", bus.icache_data_out, fill8(8'hA5));
    do_txn(1, -1, fill8(8'h5A));

    // Flush during WAIT drops the fetch
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h4010;
    do_txn(4, 2, fill8(8'hC3));
    check("t3_ic_kept", bus.icache_data_out, fill8(8'h5A));
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h5000;
    do_txn(1, -1, fill8(8'h77));

    // Flush coincident with data valid
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h5040;
    do_txn(2, 2, fill8(8'h99));
    check("t3b_ic_kept", bus.icache_data_out, fill8(8'h77));

    // dcache read is immune to flush
    bus.dcache_req     = 1'b1;
    bus.dcache_address = 64'h6abc;
    bus.dcache_wr_en   = 1'b0;
    do_txn(2, 1, fill8(8'h3C));

    // icache is masked while flush is held in IDLE
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h7000;
    bus.flush          = 1'b1;
    tick();
    tick();
    check("mask_busy", bus.busy, '0);
    bus.flush = 1'b0;
    do_txn(1, -1, rand_blk());

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if (!bus.icache_req) begin
        bus.icache_req     = 1'($urandom_range(0, 1));
        bus.icache_address = {$urandom, $urandom};
      end
      if (!bus.dcache_req) begin
        bus.dcache_req     = 1'($urandom_range(0, 1));
        bus.dcache_address = {$urandom, $urandom};
        bus.dcache_wr_en   = 1'($urandom_range(0, 1));
        bus.dcache_data_in = rand_blk();
      end
      if (!bus.icache_req && !bus.dcache_req) bus.icache_req = 1'b1;
      lat = $urandom_range(1, 5);
      fat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
      do_txn(lat, fat, rand_blk());
    end

    // Reset mid-transaction, then a late valid
    bus.icache_req     = 1'b0;
    bus.dcache_req     = 1'b0;
    tick();
    bus.icache_req     = 1'b1;
    bus.icache_address = 64'h8000;
    tick();
    check("rst_mid_req", bus.mem_req, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    bus.icache_req = 1'b0;
    check_all_zero("rst_async");
    bus.mem_data_valid = 1'b1;
    bus.data_from_mem  = rand_blk();
    tick();
    reset = 1'b0;
    tick();
    bus.mem_data_valid = 1'b0;
    check_all_zero("rst_after");
    ref_ic_data = '0;
    ref_dc_data = '0;
    ref_starve  = 0;

    // Both caches requesting back-to-back
    grant_log = "";
    for (int n = 0; n < 6; n++) begin
      bus.icache_req     = 1'b1;
      bus.icache_address = 64'h9000 + 64'(n * 64);
      bus.dcache_req     = 1'b1;
      bus.dcache_address = 64'hA000 + 64'(n * 64);
      bus.dcache_wr_en   = 1'b0;
      do_txn(1, -1, rand_blk());
    end
`ifdef STARVE_GUARD_EN
    exp_order = "DDDDID";
`else
    exp_order = "DDDDDD";
`endif
    total++;
    assert (grant_log == exp_order) else begin
      bad++;
      $error("FAIL grant_order observed=%s expected=%s", grant_log, exp_order);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
